// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: a single full-adder cell walks an operand pair LSB first,
// one bit per clock, behind a start/busy/done handshake.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);
    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_nxt;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt;
    logic             capture;
    logic             last_bit;
    logic [1:0]       fa_out;

    // Returns {carry, sum} of one bit position.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(y & c) | (x & c) | (x & y), x ^ y ^ c};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fa_out   = full_add(a_reg[0], b_reg[0], carry_reg);
    assign last_bit = (cnt == LAST_BIT);

    // New sum bit enters at the MSB so the first (LSB) result lands at bit 0.
    always_comb begin
        res_nxt            = res_reg >> 1;
        res_nxt[WIDTH-1]   = fa_out[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            S         <= '0;
            Cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (capture) begin
            a_reg     <= a;
            b_reg     <= b;
            res_reg   <= '0;
            carry_reg <= Cin;
            cnt       <= '0;
        end else if (busy) begin
            a_reg     <= a_reg >> 1;
            b_reg     <= b_reg >> 1;
            res_reg   <= res_nxt;
            carry_reg <= fa_out[1];
            cnt       <= cnt + 1'b1;
            // On the final bit carry_reg still holds the carry into the MSB.
            if (last_bit) begin
                S    <= res_nxt;
                Cout <= fa_out[1];
                ovf  <= carry_reg ^ fa_out[1];
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized bench for serial_adder_ctrl at WIDTH=8, with a
// scoreboard queue of expected results filled at start and drained on done.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done;
    logic [W-1:0] S;
    logic         Cout, ovf;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   done_cyc = 0;
    int   prev_done_cyc;
    int   dcount;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .Cin(cin),
        .busy(busy), .done(done), .S(S), .Cout(Cout), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] full;
        exp_t       e;
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.s    = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                               input bit push);
        @(posedge clk); #1;
        a = x; b = y; cin = c; start = 1'b1;
        if (push) sb.push_back(model(x, y, c));
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_done(input int exp_busy);
        int   n = 0, nb = 0, both = 0;
        bit   got = 0;
        exp_t e;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (busy && done) both++;
            if (done) got = 1;
            else if (busy) nb++;
        end
        done_cyc = cyc;
        check("done_seen", 32'(got), 32'd1);
        check("busy_cycles", 32'(nb), 32'(exp_busy));
        check("busy_done_excl", 32'(both), 32'd0);
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            check("sum", 32'(S), 32'(e.s));
            check("cout", 32'(Cout), 32'(e.cout));
            check("ovf", 32'(ovf), 32'(e.ovf));
        end
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        issue_start(x, y, c, 1'b1);
        wait_done(W);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);
    endtask

    task automatic count_done(input int ncyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_S", 32'(S), 32'd0);
        check("rst_cout", 32'(Cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        #11 rst_n = 1'b1;

        do_op(8'h5A, 8'h3C, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'h7F, 8'h00, 1'b1);

        // Start while running is ignored
        issue_start(8'h10, 8'h20, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1; a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(W - 3);
        count_done(12, dcount);
        check("single_done", 32'(dcount), 32'd0);

        // Asynchronous reset mid-run
        issue_start(8'h80, 8'h80, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("busy_before_rst", 32'(busy), 32'd1);
        check("S_before_rst", 32'(S), 32'h30);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_S", 32'(S), 32'd0);
        check("arst_cout", 32'(Cout), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_done(12, dcount);
        check("no_done_after_abort", 32'(dcount), 32'd0);
        do_op(8'h01, 8'h01, 1'b0);

        // Back-to-back: start held through the DONE cycle
        issue_start(8'h12, 8'h34, 1'b1, 1'b1);
        wait_done(W);
        prev_done_cyc = done_cyc;
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        sb.push_back(model(8'h0F, 8'h01, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_no_done", 32'(done), 32'd0);
        wait_done(W);
        check("b2b_spacing", 32'(done_cyc - prev_done_cyc), 32'd9);
        check("b2b_S", 32'(S), 32'h10);
        @(negedge clk);

        for (int i = 0; i < 1000; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom));

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
